// File: rtl/i2s_slave_rx_pkg.sv
// rtl/i2s_slave_rx_pkg.sv - shared I2S receiver definitions: states, channel codes, default width
package i2s_slave_rx_pkg;

  localparam int   DW_DEFAULT = 32;
  localparam logic CH_LEFT    = 1'b0;
  localparam logic CH_RIGHT   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY_L,
    ST_SHIFT_L,
    ST_DONE_L,
    ST_DELAY_R,
    ST_SHIFT_R,
    ST_DONE_R
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_fifo.sv
// rtl/i2s_rx_fifo.sv - show-ahead synchronous FIFO holding left/right sample pairs
module i2s_rx_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO only lands when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/i2s_slave_rx.sv
// rtl/i2s_slave_rx.sv - I2S clock-slave receiver rebuilding left/right words into a pair stream
module i2s_slave_rx
  import i2s_slave_rx_pkg::*;
#(
  parameter int DW          = DW_DEFAULT,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          bclk_i,
  input  logic                          lrclk_i,
  input  logic                          sdin,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DW-1:0]                 m_data_l,
  output logic [DW-1:0]                 m_data_r,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          err_clr
);

  localparam int CW = $clog2(DW);

  logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sd_sync;
  logic                   bclk_prev, lr_prev;
  logic                   bclk_rise, lr_rise, lr_fall, sd_cur;

  rx_state_e     state, state_nx;
  logic [CW-1:0] bitcnt, bitcnt_nx;
  logic [DW-1:0] word_l, word_r;
  logic          left_valid, left_valid_nx;
  logic          push_q, push_nx;
  logic          cap, chan, ferr_set, last_bit;
  logic          full, empty, pop, fifo_drop;
  logic [2*DW-1:0] head;

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      bclk_prev <= 1'b0;
      lr_prev   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk_i};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk_i};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sdin};
      bclk_prev <= bclk_sync[SYNC_STAGES-1];
      lr_prev   <= lr_sync[SYNC_STAGES-1];
    end
  end

  assign bclk_rise = ~bclk_prev & bclk_sync[SYNC_STAGES-1];
  assign lr_rise   = ~lr_prev & lr_sync[SYNC_STAGES-1];
  assign lr_fall   = lr_prev & ~lr_sync[SYNC_STAGES-1];
  assign sd_cur    = sd_sync[SYNC_STAGES-1];
  assign last_bit  = (bitcnt == CW'(DW - 1));
  assign chan      = (state == ST_SHIFT_R) ? CH_RIGHT : CH_LEFT;

  always_comb begin
    state_nx      = state;
    bitcnt_nx     = bitcnt;
    left_valid_nx = left_valid;
    push_nx       = 1'b0;
    ferr_set      = 1'b0;
    cap           = 1'b0;
    if (!enable) begin
      state_nx      = ST_IDLE;
      left_valid_nx = 1'b0;
    end else begin
      case (state)
        ST_IDLE:   if (lr_fall) state_nx = ST_DELAY_L;
        ST_DONE_L: if (lr_rise) state_nx = ST_DELAY_R;
        ST_DONE_R: if (lr_fall) state_nx = ST_DELAY_L;
        ST_DELAY_L, ST_DELAY_R, ST_SHIFT_L, ST_SHIFT_R: begin
          // word select moved before the word finished: resync on the new channel
          if (lr_fall || lr_rise) begin
            ferr_set      = 1'b1;
            left_valid_nx = 1'b0;
            state_nx      = lr_fall ? ST_DELAY_L : ST_DELAY_R;
          end else if (bclk_rise) begin
            if (state == ST_DELAY_L || state == ST_DELAY_R) begin
              state_nx  = (state == ST_DELAY_L) ? ST_SHIFT_L : ST_SHIFT_R;
              bitcnt_nx = '0;
            end else begin
              cap       = 1'b1;
              bitcnt_nx = bitcnt + CW'(1);
              if (last_bit) begin
                if (chan == CH_LEFT) begin
                  state_nx      = ST_DONE_L;
                  left_valid_nx = 1'b1;
                end else begin
                  state_nx      = ST_DONE_R;
                  push_nx       = left_valid;
                  left_valid_nx = 1'b0;
                end
              end
            end
          end
        end
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bitcnt     <= '0;
      left_valid <= 1'b0;
      push_q     <= 1'b0;
      word_l     <= '0;
      word_r     <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nx;
      bitcnt     <= bitcnt_nx;
      left_valid <= left_valid_nx;
      push_q     <= push_nx;
      if (cap) begin
        if (chan == CH_RIGHT) word_r[bitcnt] <= sd_cur;
        else                  word_l[bitcnt] <= sd_cur;
      end
      overflow  <= fifo_drop | (overflow & ~err_clr);
      frame_err <= ferr_set | (frame_err & ~err_clr);
    end
  end

  assign m_valid   = ~empty;
  assign pop       = m_valid & m_ready;
  assign fifo_drop = push_q & full & ~pop;
  assign m_data_l  = head[2*DW-1:DW];
  assign m_data_r  = head[DW-1:0];

  i2s_rx_fifo #(
    .W     (2 * DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata ({word_l, word_r}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_i2s_slave_rx.sv
// tb/tb_i2s_slave_rx.sv - scoreboard bench for i2s_slave_rx driven by an I2S transmitter model
module tb_i2s_slave_rx;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SS    = 2;
  localparam int HALF  = 5;

  logic          clk = 1'b0;
  logic          rst, enable, bclk_i, lrclk_i, sdin, m_ready, err_clr;
  logic          m_valid, overflow, frame_err;
  logic [DW-1:0] m_data_l, m_data_r;
  logic [3:0]    fifo_level;

  int            errors = 0;
  int            checks = 0;
  logic [63:0]   exp_q[$];
  logic [63:0]   mon_e;
  logic [DW-1:0] l_hold;
  bit            left_ok, stall, force_drop;
  int            hook;

  always #5 clk = ~clk;

  i2s_slave_rx #(.DW(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bclk_i(bclk_i), .lrclk_i(lrclk_i),
    .sdin(sdin), .m_valid(m_valid), .m_ready(m_ready), .m_data_l(m_data_l),
    .m_data_r(m_data_r), .fifo_level(fifo_level), .overflow(overflow),
    .frame_err(frame_err), .err_clr(err_clr)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Observer/actor fired when the last right data bit's bclk rises (cycle c).
  task automatic hook_proc(int h);
    tick(3);
    if (h == 1) begin
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
    end else if (h == 2) begin
      check("lat_before_t2", 64'(m_valid), 64'(0));
      tick(1);
      check("lat_at_t2", 64'(m_valid), 64'(1));
    end
  endtask

  task automatic send_bit(logic lr, logic d, bit trig);
    bclk_i  = 1'b0;
    lrclk_i = lr;
    sdin    = d;
    tick(HALF);
    bclk_i = 1'b1;
    if (trig) begin
      automatic int h = hook;
      fork
        hook_proc(h);
      join_none
    end
    tick(HALF);
  endtask

  // Reference model: a pair appears when a complete right word follows a complete left word.
  task automatic model_word(logic lr, logic [DW-1:0] w);
    if (lr == 1'b0) begin
      left_ok = !force_drop;
      l_hold  = w;
    end else begin
      if (left_ok && !force_drop && (!stall || hook == 1 || exp_q.size() < DEPTH))
        exp_q.push_back({l_hold, w});
      left_ok = 1'b0;
    end
  endtask

  task automatic send_channel(logic lr, logic [DW-1:0] w, int nbits);
    send_bit(lr, 1'($urandom), 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (nbits == DW && i == DW - 1) model_word(lr, w);
      send_bit(lr, w[i], (lr == 1'b1 && i == DW - 1 && hook != 0));
    end
    if (nbits == DW) send_bit(lr, 1'($urandom), 1'b0);
    else left_ok = 1'b0;
  endtask

  task automatic send_frame(logic [DW-1:0] l, logic [DW-1:0] r);
    send_channel(1'b0, l, DW);
    send_channel(1'b1, r, DW);
  endtask

  task automatic send_rand_frames(int n);
    for (int i = 0; i < n; i++) send_frame(DW'($urandom), DW'($urandom));
  endtask

  task automatic drain(string name);
    int budget;
    m_ready = 1'b1;
    stall   = 1'b0;
    budget  = 0;
    while ((exp_q.size() != 0 || m_valid) && budget < 300) begin
      tick(1);
      budget++;
    end
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({name, "_level_zero"}, 64'(fifo_level), 64'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got %h expected none", {m_data_l, m_data_r});
      end else begin
        mon_e = exp_q.pop_front();
        check("pair_data", {m_data_l, m_data_r}, mon_e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; bclk_i = 1'b1; lrclk_i = 1'b1; sdin = 1'b0;
    m_ready = 1'b0; err_clr = 1'b0;
    left_ok = 1'b0; stall = 1'b0; force_drop = 1'b0; hook = 0;
    tick(5);
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_level", 64'(fifo_level), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_data", {m_data_l, m_data_r}, 64'(0));
    rst = 1'b0;
    tick(3);

    // loopback of the fixed pattern plus random frames, with a latency probe
    enable = 1'b1; m_ready = 1'b1;
    hook = 2;
    send_frame(32'hA5A5_0001, 32'h1234_5678);
    hook = 0;
    send_frame(32'hA5A5_0001, 32'h1234_5678);
    send_rand_frames(2);
    tick(20);
    check("t1_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t1_overflow", 64'(overflow), 64'(0));
    check("t1_frame_err", 64'(frame_err), 64'(0));

    // start while lrclk is high in the middle of a right word
    enable = 1'b0; left_ok = 1'b0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom), 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) send_bit(1'b1, 1'($urandom), 1'b0);
    send_frame(DW'($urandom), DW'($urandom));
    tick(20);
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t2_frame_err", 64'(frame_err), 64'(0));

    // ten stalled frames: eight stored, two dropped with overflow
    stall = 1'b1; m_ready = 1'b0;
    send_rand_frames(10);
    tick(10);
    check("t3_level_full", 64'(fifo_level), 64'(DEPTH));
    check("t3_overflow", 64'(overflow), 64'(1));
    drain("t3");
    check("t3_overflow_sticky", 64'(overflow), 64'(1));
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("t3_overflow_clr", 64'(overflow), 64'(0));

    // full FIFO with push and pop in the same cycle
    stall = 1'b1; m_ready = 1'b0;
    send_rand_frames(DEPTH);
    tick(10);
    check("t6_level_full", 64'(fifo_level), 64'(DEPTH));
    hook = 1;
    send_frame(DW'($urandom), DW'($urandom));
    hook = 0;
    tick(10);
    check("t6_level_kept", 64'(fifo_level), 64'(DEPTH));
    check("t6_no_overflow", 64'(overflow), 64'(0));
    drain("t6");

    // word select toggles after 20 left bits
    send_channel(1'b0, DW'($urandom), 20);
    send_channel(1'b1, DW'($urandom), DW);
    tick(2);
    check("t4_frame_err_set", 64'(frame_err), 64'(1));
    send_frame(DW'($urandom), DW'($urandom));
    tick(20);
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t4_frame_err_sticky", 64'(frame_err), 64'(1));
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("t4_frame_err_clr", 64'(frame_err), 64'(0));

    // enable dropped mid-word for 100 clk with pairs already queued
    stall = 1'b1; m_ready = 1'b0;
    send_rand_frames(2);
    force_drop = 1'b1;
    fork
      begin
        tick(130);
        enable = 1'b0;
        tick(100);
        enable = 1'b1;
      end
    join_none
    send_frame(DW'($urandom), DW'($urandom));
    force_drop = 1'b0;
    send_frame(DW'($urandom), DW'($urandom));
    tick(10);
    check("t5_level", 64'(fifo_level), 64'(3));
    check("t5_frame_err", 64'(frame_err), 64'(0));
    drain("t5");

    // reset pulse mid-word with data queued and a frame error pending
    stall = 1'b1; m_ready = 1'b0;
    send_rand_frames(2);
    send_channel(1'b0, DW'($urandom), 10);
    send_channel(1'b1, DW'($urandom), DW);
    check("t7_pre_level", 64'(fifo_level), 64'(2));
    check("t7_pre_frame_err", 64'(frame_err), 64'(1));
    force_drop = 1'b1;
    fork
      begin
        tick(200);
        rst = 1'b1;
        tick(1);
        exp_q.delete();
        check("t7_rst_m_valid", 64'(m_valid), 64'(0));
        check("t7_rst_level", 64'(fifo_level), 64'(0));
        check("t7_rst_frame_err", 64'(frame_err), 64'(0));
        check("t7_rst_overflow", 64'(overflow), 64'(0));
        check("t7_rst_data", {m_data_l, m_data_r}, 64'(0));
        tick(1);
        rst = 1'b0;
      end
    join_none
    send_frame(DW'($urandom), DW'($urandom));
    force_drop = 1'b0;
    stall = 1'b0; m_ready = 1'b1;
    send_frame(DW'($urandom), DW'($urandom));
    tick(20);
    check("t7_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
